timer_pair_sequencer: RTL and testbench
=======================================

# timer_pair_sequencer

Hardware sequencer that programs and runs a chained low/high 32-bit counter-timer pair as one 64-bit down-counting period timer, with no CPU involvement. It drives the cores' native register-write ports (value, data and config write enables plus a shared write-data bus), loads a 64-bit period, starts both cores, and counts expirations. On each expiry it either restarts the pair for the next period or stops and pulses `done`. It sits between a requesting block and the low/high counter cores; the Wishbone wrappers remain the CPU path.

## Interface
Parameters:
- CFG_RUN, 5'b01011, config word while running: chain=1, updown=0 (down), oneshot=1, enable=1, irq_ena=0.
- CFG_HALT, 5'b01010, config word for halting: CFG_RUN with enable=0.

Ports:
- clkin  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; honoured only in IDLE.
- abort  in  1  single-cycle request; honoured in any state except IDLE and HALT_LO/HALT_HI.
- period  in  64  period value, sampled on an accepted start.
- repeat_n  in  8  number of periods to run, sampled on an accepted start; 0 = run until abort.
- expire_in  in  1  stop_out of the high core.
- wdata  out  32  shared write data to both cores.
- lo_val_we, lo_dat_we  out  4 each  byte write enables, low core.
- hi_val_we, hi_dat_we  out  4 each  byte write enables, high core.
- lo_cfg_we, hi_cfg_we  out  1 each  config write enables.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  single-cycle pulse on normal completion.
- period_cnt  out  8  count of completed periods since the last accepted start.

## Operation
States: IDLE, LD_LO_VAL, LD_HI_VAL, LD_LO_DAT, LD_HI_DAT, CFG_HI, CFG_LO, RUN, RST_LO, HALT_LO, HALT_HI.

Write states (exactly one write strobe per cycle; each listed value appears on wdata in that cycle):
- LD_LO_VAL: lo_val_we=4'hF, wdata=period[31:0].
- LD_HI_VAL: hi_val_we=4'hF, wdata=period[63:32].
- LD_LO_DAT: lo_dat_we=4'hF, wdata=period[31:0].
- LD_HI_DAT: hi_dat_we=4'hF, wdata=period[63:32].
- CFG_HI: hi_cfg_we=1, wdata={27'd0,CFG_RUN}. The high core is written first so that it waits for the low core's enable.
- CFG_LO: lo_cfg_we=1, wdata={27'd0,CFG_RUN}.
- RST_LO: lo_cfg_we=1, wdata={27'd0,CFG_HALT}.
- HALT_LO: lo_cfg_we=1, wdata={27'd0,CFG_HALT}.
- HALT_HI: hi_cfg_we=1, wdata={27'd0,CFG_HALT}.

Transitions:
- IDLE, start=1: latch period and repeat_n, clear period_cnt, go to LD_LO_VAL.
- Each write state advances to the next unconditionally; CFG_LO goes to RUN.
- RUN, rising edge of expire_in: increment period_cnt (8-bit, wraps 255→0).
  - If repeat_n≠0 and this is period number repeat_n: go to HALT_LO and flag completion.
  - Otherwise go to RST_LO, then CFG_LO. Disabling and re-enabling the low core reloads both cores from their value registers.
- Any eligible state, abort=1: go to HALT_LO and clear the completion flag. abort takes priority over an expire edge in the same cycle.
- HALT_LO → HALT_HI → IDLE. done pulses in the IDLE-entry cycle only if the completion flag is set.
- Outside the write states, all write enables are 0 and wdata is 0.
- Edge detect: expire_d is registered every cycle; an edge is expire_in & ~expire_d, evaluated only in RUN. Edges outside RUN are ignored.
- start outside IDLE is ignored. A start and an abort in the same IDLE cycle: start is accepted and abort is ignored.
- repeat_n=0 means the sequencer restarts indefinitely. period_cnt keeps counting and wraps.

## Timing
- Reset: state IDLE; wdata, all write enables, busy, done, period_cnt and expire_d are 0; latched period and repeat are 0.
- Start accepted in cycle T: LD_LO_VAL in T+1, CFG_LO in T+6, RUN from T+7. busy is high from T+1.
- Expire edge seen in RUN at cycle E (restart case): RST_LO in E+1, CFG_LO in E+2, RUN in E+3.
- Final expiry at E: HALT_LO in E+1, HALT_HI in E+2, IDLE and done=1 in E+3, done=0 in E+4.
- period_cnt updates in cycle E+1.
- Abort at cycle A: HALT_LO in A+1, IDLE in A+3, done stays 0.
- An asynchronous reset in mid-sequence returns to IDLE immediately. No further halt writes are issued; the cores are expected to share the same reset.
- Every output is registered.

## Test plan
- Reset: resetn low with start/abort toggling → all outputs 0, state IDLE; after release, busy stays 0 until start.
- Single period: period=64'h0000_0002_0000_0010, repeat_n=1, start → cycles T+1..T+6 show exactly one strobe each with wdata 0x10, 0x2, 0x10, 0x2, 0x0B, 0x0B; expire edge → HALT writes of 0x0A (lo, then hi); done high for exactly 1 cycle at E+3; period_cnt=1.
- Repeat 3: repeat_n=3 with three expire pulses → RST_LO/CFG_LO pair (0x0A then 0x0B on lo_cfg_we) after the first two pulses; done after the third; period_cnt=3.
- Infinite with wrap: repeat_n=0 and 256 expire pulses → no done, period_cnt=0; a level-held expire_in counts once per rising edge.
- Abort: abort during LD_HI_DAT, then separately in RUN on the same cycle as an expire edge → HALT_LO/HALT_HI writes, IDLE, done=0, period_cnt unchanged.
- Ignored requests: start while busy, and an expire edge while in IDLE → no state change, no write strobes.

Source files
------------

// File: rtl/timer_pair_sequencer.sv
// Programs and runs a chained low/high counter-timer pair as one 64-bit period timer,
// restarting it for repeat_n periods (or forever) and pulsing done on normal completion.
module timer_pair_sequencer #(
  parameter logic [4:0] CFG_RUN  = 5'b01011,
  parameter logic [4:0] CFG_HALT = 5'b01010
) (
  input  logic        clkin,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] period,
  input  logic [7:0]  repeat_n,
  input  logic        expire_in,
  output logic [31:0] wdata,
  output logic [3:0]  lo_val_we,
  output logic [3:0]  lo_dat_we,
  output logic [3:0]  hi_val_we,
  output logic [3:0]  hi_dat_we,
  output logic        lo_cfg_we,
  output logic        hi_cfg_we,
  output logic        busy,
  output logic        done,
  output logic [7:0]  period_cnt
);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StLdLoVal = 4'd1;
  localparam logic [3:0] StLdHiVal = 4'd2;
  localparam logic [3:0] StLdLoDat = 4'd3;
  localparam logic [3:0] StLdHiDat = 4'd4;
  localparam logic [3:0] StCfgHi   = 4'd5;
  localparam logic [3:0] StCfgLo   = 4'd6;
  localparam logic [3:0] StRun     = 4'd7;
  localparam logic [3:0] StRstLo   = 4'd8;
  localparam logic [3:0] StHaltLo  = 4'd9;
  localparam logic [3:0] StHaltHi  = 4'd10;

  logic [3:0]  state_q, state_d;
  logic [63:0] period_q, period_d;
  logic [7:0]  repeat_q, repeat_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        flag_q, flag_d;
  logic        expire_q;
  logic        expire_edge;
  logic        abort_ok;

  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  lo_val_we_q, lo_val_we_d, hi_val_we_q, hi_val_we_d;
  logic [3:0]  lo_dat_we_q, lo_dat_we_d, hi_dat_we_q, hi_dat_we_d;
  logic        lo_cfg_we_q, lo_cfg_we_d, hi_cfg_we_q, hi_cfg_we_d;
  logic        busy_q, busy_d, done_q, done_d;

  assign expire_edge = expire_in & ~expire_q;
  assign abort_ok    = abort && (state_q != StIdle) && (state_q != StHaltLo) &&
                       (state_q != StHaltHi);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    repeat_d = repeat_q;
    cnt_d    = cnt_q;
    flag_d   = flag_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StLdLoVal;
          period_d = period;
          repeat_d = repeat_n;
          cnt_d    = 8'd0;
          flag_d   = 1'b0;
        end
      end
      StLdLoVal: state_d = StLdHiVal;
      StLdHiVal: state_d = StLdLoDat;
      StLdLoDat: state_d = StLdHiDat;
      StLdHiDat: state_d = StCfgHi;
      StCfgHi:   state_d = StCfgLo;
      StCfgLo:   state_d = StRun;
      StRun: begin
        if (expire_edge) begin
          cnt_d = cnt_q + 8'd1;
          if ((repeat_q != 8'd0) && (cnt_d == repeat_q)) begin
            state_d = StHaltLo;
            flag_d  = 1'b1;
          end else begin
            state_d = StRstLo;
          end
        end
      end
      StRstLo:  state_d = StCfgLo;
      StHaltLo: state_d = StHaltHi;
      StHaltHi: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // Abort wins over a same-cycle expiry: that period is not counted.
    if (abort_ok) begin
      state_d = StHaltLo;
      flag_d  = 1'b0;
      cnt_d   = cnt_q;
    end
  end

  // Outputs are decoded from the next state so the strobes appear in the state's own cycle.
  always_comb begin
    wdata_d     = 32'd0;
    lo_val_we_d = 4'h0;
    hi_val_we_d = 4'h0;
    lo_dat_we_d = 4'h0;
    hi_dat_we_d = 4'h0;
    lo_cfg_we_d = 1'b0;
    hi_cfg_we_d = 1'b0;
    case (state_d)
      StLdLoVal: begin lo_val_we_d = 4'hF; wdata_d = period_d[31:0];  end
      StLdHiVal: begin hi_val_we_d = 4'hF; wdata_d = period_d[63:32]; end
      StLdLoDat: begin lo_dat_we_d = 4'hF; wdata_d = period_d[31:0];  end
      StLdHiDat: begin hi_dat_we_d = 4'hF; wdata_d = period_d[63:32]; end
      StCfgHi:   begin hi_cfg_we_d = 1'b1; wdata_d = {27'd0, CFG_RUN};  end
      StCfgLo:   begin lo_cfg_we_d = 1'b1; wdata_d = {27'd0, CFG_RUN};  end
      StRstLo:   begin lo_cfg_we_d = 1'b1; wdata_d = {27'd0, CFG_HALT}; end
      StHaltLo:  begin lo_cfg_we_d = 1'b1; wdata_d = {27'd0, CFG_HALT}; end
      StHaltHi:  begin hi_cfg_we_d = 1'b1; wdata_d = {27'd0, CFG_HALT}; end
      default: ;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_q == StHaltHi) && flag_q;
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      period_q    <= 64'd0;
      repeat_q    <= 8'd0;
      cnt_q       <= 8'd0;
      flag_q      <= 1'b0;
      expire_q    <= 1'b0;
      wdata_q     <= 32'd0;
      lo_val_we_q <= 4'h0;
      hi_val_we_q <= 4'h0;
      lo_dat_we_q <= 4'h0;
      hi_dat_we_q <= 4'h0;
      lo_cfg_we_q <= 1'b0;
      hi_cfg_we_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      repeat_q    <= repeat_d;
      cnt_q       <= cnt_d;
      flag_q      <= flag_d;
      expire_q    <= expire_in;
      wdata_q     <= wdata_d;
      lo_val_we_q <= lo_val_we_d;
      hi_val_we_q <= hi_val_we_d;
      lo_dat_we_q <= lo_dat_we_d;
      hi_dat_we_q <= hi_dat_we_d;
      lo_cfg_we_q <= lo_cfg_we_d;
      hi_cfg_we_q <= hi_cfg_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign wdata      = wdata_q;
  assign lo_val_we  = lo_val_we_q;
  assign hi_val_we  = hi_val_we_q;
  assign lo_dat_we  = lo_dat_we_q;
  assign hi_dat_we  = hi_dat_we_q;
  assign lo_cfg_we  = lo_cfg_we_q;
  assign hi_cfg_we  = hi_cfg_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign period_cnt = cnt_q;

endmodule

// File: tb/tb_timer_pair_sequencer.sv
// Scoreboard bench: every strobe/done observed on the DUT is popped against the
// expected write sequence queued when the stimulus was driven.
module tb_timer_pair_sequencer;

  localparam logic [31:0] Run  = 32'h0B;
  localparam logic [31:0] Halt = 32'h0A;
  localparam logic [2:0] EvLoVal = 3'd0, EvHiVal = 3'd1, EvLoDat = 3'd2, EvHiDat = 3'd3;
  localparam logic [2:0] EvLoCfg = 3'd4, EvHiCfg = 3'd5, EvDone = 3'd6;

  typedef struct packed {
    logic [2:0]  code;
    logic [31:0] data;
  } ev_t;

  logic        clkin = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [63:0] period = 64'd0;
  logic [7:0]  repeat_n = 8'd0;
  logic        expire_in = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  lo_val_we, lo_dat_we, hi_val_we, hi_dat_we;
  logic        lo_cfg_we, hi_cfg_we, busy, done;
  logic [7:0]  period_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  ev_t         exp_q[$];
  logic [7:0]  exp_cnt = 8'd0;

  timer_pair_sequencer dut (
    .clkin      (clkin),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .period     (period),
    .repeat_n   (repeat_n),
    .expire_in  (expire_in),
    .wdata      (wdata),
    .lo_val_we  (lo_val_we),
    .lo_dat_we  (lo_dat_we),
    .hi_val_we  (hi_val_we),
    .hi_dat_we  (hi_dat_we),
    .lo_cfg_we  (lo_cfg_we),
    .hi_cfg_we  (hi_cfg_we),
    .busy       (busy),
    .done       (done),
    .period_cnt (period_cnt)
  );

  always #5 clkin = ~clkin;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] code, input logic [31:0] data);
    ev_t e;
    e.code = code;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  // Monitor: one event per cycle at most, compared in order against the scoreboard.
  always @(negedge clkin) begin
    int          n;
    logic [2:0]  code;
    logic [3:0]  we;
    ev_t         e;
    if (resetn) begin
      n = int'(lo_val_we != 0) + int'(hi_val_we != 0) + int'(lo_dat_we != 0) +
          int'(hi_dat_we != 0) + int'(lo_cfg_we) + int'(hi_cfg_we) + int'(done);
      we = 4'hF;
      if      (lo_val_we != 0) begin code = EvLoVal; we = lo_val_we; end
      else if (hi_val_we != 0) begin code = EvHiVal; we = hi_val_we; end
      else if (lo_dat_we != 0) begin code = EvLoDat; we = lo_dat_we; end
      else if (hi_dat_we != 0) begin code = EvHiDat; we = hi_dat_we; end
      else if (lo_cfg_we)      code = EvLoCfg;
      else if (hi_cfg_we)      code = EvHiCfg;
      else                     code = EvDone;
      if (n == 0) begin
        if (wdata != 0) check_eq("idle_wdata", 64'(wdata), 64'd0);
      end else begin
        if (n > 1) check_eq("one_strobe", 64'(n), 64'd1);
        check_eq("we_bytes", 64'(we), 64'hF);
        check_eq("sb_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("evt_code", 64'(code), 64'(e.code));
          check_eq("evt_data", 64'(wdata), 64'(e.data));
        end
      end
    end
  end

  task automatic do_start(input logic [63:0] p, input logic [7:0] r);
    push(EvLoVal, p[31:0]);
    push(EvHiVal, p[63:32]);
    push(EvLoDat, p[31:0]);
    push(EvHiDat, p[63:32]);
    push(EvHiCfg, Run);
    push(EvLoCfg, Run);
    period = p;
    repeat_n = r;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_cnt = 8'd0;
    check_eq("busy_t1", 64'(busy), 64'd1);
    check_eq("cnt_clr", 64'(period_cnt), 64'd0);
    repeat (6) tick();
  endtask

  task automatic expire_pulse(input bit final_p);
    push(EvLoCfg, Halt);
    if (final_p) begin
      push(EvHiCfg, Halt);
      push(EvDone, 32'd0);
    end else begin
      push(EvLoCfg, Run);
    end
    expire_in = 1'b1;
    tick();
    expire_in = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    check_eq("period_cnt", 64'(period_cnt), 64'(exp_cnt));
    tick();
    tick();
    if (final_p) begin
      check_eq("done_e3", 64'(done), 64'd1);
      check_eq("busy_e3", 64'(busy), 64'd0);
      tick();
      check_eq("done_e4", 64'(done), 64'd0);
    end else begin
      check_eq("busy_run", 64'(busy), 64'd1);
    end
  endtask

  task automatic abort_halt();
    push(EvLoCfg, Halt);
    push(EvHiCfg, Halt);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expire_in = 1'b0;
    tick();
    tick();
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_cnt", 64'(period_cnt), 64'(exp_cnt));
  endtask

  initial begin
    // Reset held while requests toggle.
    repeat (4) begin
      start = ~start;
      abort = ~abort;
      @(negedge clkin);
      check_eq("rst_outs", {wdata, lo_val_we, lo_dat_we, hi_val_we, hi_dat_we,
                            lo_cfg_we, hi_cfg_we, busy, done, period_cnt}, 64'd0);
    end
    start = 1'b0;
    abort = 1'b0;
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    check_eq("post_rst_busy", 64'(busy), 64'd0);

    // Single period.
    do_start(64'h0000_0002_0000_0010, 8'd1);
    check_eq("run_busy", 64'(busy), 64'd1);
    expire_pulse(1'b1);
    check_eq("sb_empty1", 64'(exp_q.size()), 64'd0);

    // Repeat 3, with an ignored start while running.
    do_start(64'h1234_5678_9ABC_DEF0, 8'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_eq("start_ignored", 64'(busy), 64'd1);
    expire_pulse(1'b0);
    expire_pulse(1'b0);
    expire_pulse(1'b1);
    check_eq("cnt_rep3", 64'(period_cnt), 64'd3);

    // Expire edge while idle is ignored.
    expire_in = 1'b1;
    tick();
    expire_in = 1'b0;
    repeat (3) tick();
    check_eq("idle_expire_busy", 64'(busy), 64'd0);
    check_eq("idle_expire_cnt", 64'(period_cnt), 64'd3);

    // Infinite with wrap; first pulse held high for several cycles.
    do_start(64'h0000_0000_0000_0005, 8'd0);
    push(EvLoCfg, Halt);
    push(EvLoCfg, Run);
    expire_in = 1'b1;
    tick();
    exp_cnt = exp_cnt + 8'd1;
    repeat (5) tick();
    expire_in = 1'b0;
    tick();
    check_eq("held_once", 64'(period_cnt), 64'd1);
    repeat (255) expire_pulse(1'b0);
    check_eq("cnt_wrap", 64'(period_cnt), 64'd0);
    abort_halt();

    // Abort during LD_HI_DAT.
    push(EvLoVal, 32'hAAAA_0001);
    push(EvHiVal, 32'h0000_0000);
    push(EvLoDat, 32'hAAAA_0001);
    push(EvHiDat, 32'h0000_0000);
    period = 64'h0000_0000_AAAA_0001;
    repeat_n = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_cnt = 8'd0;
    repeat (3) tick();
    abort_halt();

    // Abort in RUN coinciding with an expire edge.
    do_start(64'h0000_0001_0000_0000, 8'd3);
    expire_pulse(1'b0);
    expire_in = 1'b1;
    abort_halt();
    repeat (2) tick();
    check_eq("sb_empty_end", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
